// File: rtl/soc_system_button_pkg.sv
// Shared types and helpers for the push-button conditioning block.
package soc_system_button_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } dbnc_state_t;

  localparam int DEBOUNCE_CYCLES_50MHZ_20MS = 1000000;

  // Bits needed to hold 0..v-1; never less than 1.
  function automatic int clog2(input int unsigned v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/soc_system_button_debounce_chan.sv
// One button channel: 2-FF synchroniser, polarity fix-up, counter debounce
// and registered press/release pulses.
module soc_system_button_debounce_chan
  import soc_system_button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ_20MS,
  parameter bit INVERT          = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int               CNT_W   = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             REL_PIN = INVERT;

  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
      $error("soc_system_button_debounce_chan: DEBOUNCE_CYCLES must be >= 2");
    end
  endgenerate

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dbnc_state_t      state_q, state_d;
  logic             s;

  assign s = sync2_q ^ INVERT;

  always_comb begin
    level_d   = level_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s == level_q) begin
      // Any disagreement shorter than the window is dropped here.
      cnt_d   = '0;
      state_d = STABLE;
    end else if (cnt_q == CNT_MAX) begin
      level_d   = s;
      cnt_d     = '0;
      state_d   = STABLE;
      press_d   = s;
      release_d = ~s;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = COUNTING;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= REL_PIN;
      sync2_q   <= REL_PIN;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
      state_q   <= STABLE;
    end else begin
      sync1_q   <= button_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/soc_system_button_debounce.sv
// Board push-button conditioning ahead of the button PIO; one independent
// channel instance per pin.
module soc_system_button_debounce
  import soc_system_button_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ_20MS,
  parameter bit INVERT          = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] button_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    soc_system_button_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (INVERT)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .button_raw (button_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule

// File: tb/tb_soc_system_button_debounce.sv
// Directed scenarios plus random pin activity, every edge checked against a
// history-based model: a change is accepted once the last N synchronised
// samples all disagree with the current level.
module tb_soc_system_button_debounce;

  localparam int             W   = 2;
  localparam int             N   = 8;
  localparam bit             INV = 1'b1;
  localparam logic [W-1:0]   REL = {W{INV}};

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] button_raw;
  logic [W-1:0] btn_level, btn_press, btn_release;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] pq[$];
  logic [W-1:0] sh[$];
  logic [W-1:0] m_level, m_press, m_release;

  soc_system_button_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(N),
    .INVERT         (INV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .button_raw (button_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: update the reference model, then compare just after the edge.
  task automatic step();
    logic [W-1:0] s;
    bit           all_diff;
    @(posedge clk);
    if (reset) begin
      pq = {REL, REL};
      sh = {};
      m_level = '0; m_press = '0; m_release = '0;
    end else begin
      s = pq[pq.size()-2] ^ {W{INV}};
      pq.push_back(button_raw);
      if (pq.size() > 4) void'(pq.pop_front());
      sh.push_back(s);
      if (sh.size() > N) void'(sh.pop_front());
      m_press = '0; m_release = '0;
      for (int c = 0; c < W; c++) begin
        all_diff = (sh.size() == N);
        for (int k = 0; k < sh.size(); k++)
          if (sh[k][c] == m_level[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[c]   = ~m_level[c];
          m_press[c]   = m_level[c];
          m_release[c] = ~m_level[c];
        end
      end
    end
    #1;
    chk("level",   32'(btn_level),   32'(m_level));
    chk("press",   32'(btn_press),   32'(m_press));
    chk("release", 32'(btn_release), 32'(m_release));
    chk("press_and_release", 32'(btn_press & btn_release), 32'd0);
  endtask

  task automatic watch(input int ch, input logic val, input int n,
                       output int first, output int np, output int nr);
    first = -1; np = 0; nr = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (first < 0 && btn_level[ch] === val) first = i;
      if (btn_press[ch] === 1'b1) np++;
      if (btn_release[ch] === 1'b1) nr++;
    end
  endtask

  initial begin
    int first, np, nr, tot, cnt11;
    int hold;
    pq = {REL, REL};
    m_level = '0; m_press = '0; m_release = '0;

    // 1: reset with pins released, then quiet
    reset = 1'b1; button_raw = 2'b11;
    repeat (3) step();
    reset = 1'b0;
    chk("s1_reset_level", 32'(btn_level), 32'd0);
    watch(0, 1'b1, 20, first, np, nr);
    chk("s1_no_press", 32'(np), 32'd0);
    chk("s1_level", 32'(btn_level), 32'd0);

    // 2: clean press and release on channel 0
    button_raw[0] = 1'b0;
    watch(0, 1'b1, 14, first, np, nr);
    chk("s2_press_latency", 32'(first), 32'd10);
    chk("s2_press_count", 32'(np), 32'd1);
    chk("s2_ch1_idle", 32'(btn_level[1]), 32'd0);
    button_raw[0] = 1'b1;
    watch(0, 1'b0, 14, first, np, nr);
    chk("s2_release_latency", 32'(first), 32'd10);
    chk("s2_release_count", 32'(nr), 32'd1);

    // 3: bounce every 3 cycles, then settle low
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      button_raw[0] = (i % 2 == 1);
      watch(0, 1'b1, 3, first, np, nr);
      tot += np;
    end
    chk("s3_bounce_no_press", 32'(tot), 32'd0);
    button_raw[0] = 1'b0;
    watch(0, 1'b1, 20, first, np, nr);
    chk("s3_press_latency", 32'(first), 32'd10);
    chk("s3_press_count", 32'(np), 32'd1);
    button_raw = 2'b11;
    repeat (14) step();

    // 4: 7-cycle glitch on channel 1 is rejected
    button_raw[1] = 1'b0;
    watch(1, 1'b1, 7, first, np, nr);
    tot = np;
    button_raw[1] = 1'b1;
    watch(1, 1'b1, 20, first, np, nr);
    chk("s4_glitch_level", 32'(first), 32'hFFFF_FFFF);
    chk("s4_glitch_pulses", 32'(tot + np + nr), 32'd0);

    // 5: simultaneous press and release on both channels
    button_raw = 2'b00; cnt11 = 0;
    repeat (20) begin step(); if (btn_press === 2'b11) cnt11++; end
    chk("s5_both_press", 32'(cnt11), 32'd1);
    button_raw = 2'b11; cnt11 = 0;
    repeat (20) begin step(); if (btn_release === 2'b11) cnt11++; end
    chk("s5_both_release", 32'(cnt11), 32'd1);

    // 6: reset at cnt=5 loses the pending press; held pin re-accepted
    button_raw[0] = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    repeat (2) step();
    chk("s6_reset_no_pulse", 32'(btn_press | btn_release), 32'd0);
    reset = 1'b0;
    watch(0, 1'b1, 14, first, np, nr);
    chk("s6_press_latency", 32'(first), 32'd10);
    chk("s6_press_count", 32'(np), 32'd1);
    button_raw = 2'b11;
    repeat (14) step();

    // random pin activity with occasional reset
    repeat (60) begin
      button_raw = W'($urandom);
      reset = ($urandom_range(0, 19) == 0);
      hold = $urandom_range(1, 14);
      repeat (hold) step();
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
